// File: rtl/riscv_issue_ctrl.sv
// In-order ID->EX issue controller: gates the handshake with a FIFO scoreboard of pending destination registers.
// Optional hazard-stall performance counter enabled by defining RISCV_ISSUE_PERF_EN.
module riscv_issue_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        id_rdy,
   output logic        id_ack,
   input  logic [4:0]  id_rs1,
   input  logic        id_rs1_used,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs2_used,
   input  logic [4:0]  id_rsd,
   output logic        ex_rdy,
   input  logic        ex_ack,
   input  logic        wb_retire,
   output logic        busy,
   output logic        sb_err,
   input  logic        stall_clr,
   output logic [31:0] stall_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [DEPTH-1:0] valid_reg, valid_next;
   logic [4:0]       rsd_reg  [DEPTH];
   logic [4:0]       rsd_next [DEPTH];
   logic [PW-1:0]    wptr_reg, wptr_next;
   logic [PW-1:0]    rptr_reg, rptr_next;
   logic [PW:0]      count_reg, count_next;
   logic             sb_err_reg, sb_err_next;

   logic [DEPTH-1:0] hit1, hit2;
   logic             hazard, full, block, issue, push, pop;

   // Source compare against registered entries only; a retiring entry still blocks this cycle.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign hit1[gi] = valid_reg[gi] && (rsd_reg[gi] == id_rs1);
      assign hit2[gi] = valid_reg[gi] && (rsd_reg[gi] == id_rs2);
   end

   assign hazard = (id_rs1_used && (id_rs1 != 5'd0) && (|hit1)) ||
                   (id_rs2_used && (id_rs2 != 5'd0) && (|hit2));
   assign full   = (count_reg == FULL_CNT);
   assign block  = hazard || full;

   assign ex_rdy = rstn && id_rdy && !block;
   assign id_ack = rstn && ex_ack && !block;
   assign issue  = id_rdy && id_ack;
   assign push   = issue && (id_rsd != 5'd0);
   assign pop    = wb_retire && (count_reg != '0);

   always_comb begin
      valid_next  = valid_reg;
      rsd_next    = rsd_reg;
      wptr_next   = wptr_reg;
      rptr_next   = rptr_reg;
      count_next  = count_reg;
      sb_err_next = sb_err_reg || (wb_retire && (count_reg == '0));
      if (pop) begin
         valid_next[rptr_reg] = 1'b0;
         rptr_next            = rptr_reg + 1'b1;
      end
      if (push) begin
         valid_next[wptr_reg] = 1'b1;
         rsd_next[wptr_reg]   = id_rsd;
         wptr_next            = wptr_reg + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_reg  <= '0;
         for (int i = 0; i < DEPTH; i++) rsd_reg[i] <= 5'd0;
         wptr_reg   <= '0;
         rptr_reg   <= '0;
         count_reg  <= '0;
         sb_err_reg <= 1'b0;
      end else begin
         valid_reg  <= valid_next;
         rsd_reg    <= rsd_next;
         wptr_reg   <= wptr_next;
         rptr_reg   <= rptr_next;
         count_reg  <= count_next;
         sb_err_reg <= sb_err_next;
      end
   end

   assign busy   = (count_reg != '0);
   assign sb_err = sb_err_reg;

`ifdef RISCV_ISSUE_PERF_EN
   logic [31:0] stall_cnt_reg;

   // Clear wins over increment; count saturates instead of wrapping.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         stall_cnt_reg <= 32'd0;
      else if (stall_clr)
         stall_cnt_reg <= 32'd0;
      else if (id_rdy && block && (stall_cnt_reg != 32'hFFFF_FFFF))
         stall_cnt_reg <= stall_cnt_reg + 32'd1;
   end

   assign stall_cnt = stall_cnt_reg;
`else
   logic unused_stall_clr;
   assign unused_stall_clr = stall_clr;
   assign stall_cnt        = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_issue_ctrl.sv
// Directed bench for riscv_issue_ctrl (DEPTH=4); stall counter expectations follow RISCV_ISSUE_PERF_EN.
module tb_riscv_issue_ctrl;

   logic        clk;
   logic        rstn;
   logic        id_rdy;
   logic        id_ack;
   logic [4:0]  id_rs1;
   logic        id_rs1_used;
   logic [4:0]  id_rs2;
   logic        id_rs2_used;
   logic [4:0]  id_rsd;
   logic        ex_rdy;
   logic        ex_ack;
   logic        wb_retire;
   logic        busy;
   logic        sb_err;
   logic        stall_clr;
   logic [31:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

`ifdef RISCV_ISSUE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   riscv_issue_ctrl #(.DEPTH(4)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .id_rdy      (id_rdy),
      .id_ack      (id_ack),
      .id_rs1      (id_rs1),
      .id_rs1_used (id_rs1_used),
      .id_rs2      (id_rs2),
      .id_rs2_used (id_rs2_used),
      .id_rsd      (id_rsd),
      .ex_rdy      (ex_rdy),
      .ex_ack      (ex_ack),
      .wb_retire   (wb_retire),
      .busy        (busy),
      .sb_err      (sb_err),
      .stall_clr   (stall_clr),
      .stall_cnt   (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s got=%h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic rdy, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rsd);
      id_rdy      = rdy;
      id_rs1      = rs1;
      id_rs1_used = u1;
      id_rs2      = rs2;
      id_rs2_used = u2;
      id_rsd      = rsd;
      #1;
   endtask

   task automatic pulse_clr();
      id_rdy    = 1'b0;
      stall_clr = 1'b1;
      step();
      stall_clr = 1'b0;
   endtask

   task automatic retire_one();
      id_rdy    = 1'b0;
      wb_retire = 1'b1;
      step();
      wb_retire = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; id_rdy = 1'b1; ex_ack = 1'b1; wb_retire = 1'b0; stall_clr = 1'b0;
      id_rs1 = 5'd0; id_rs1_used = 1'b0; id_rs2 = 5'd0; id_rs2_used = 1'b0; id_rsd = 5'd0;
      #12;
      chk("rst_ex_rdy", 32'(ex_rdy), 32'd0);
      chk("rst_id_ack", 32'(id_ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sb_err", 32'(sb_err), 32'd0);
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      id_rdy = 1'b0;
      step();
      rstn = 1'b1;
      step();

      // Independent stream up to full
      offer(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd1);
      chk("ind1_ex_rdy", 32'(ex_rdy), 32'd1);
      chk("ind1_id_ack", 32'(id_ack), 32'd1);
      step();
      offer(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd2);
      chk("ind2_ex_rdy", 32'(ex_rdy), 32'd1);
      step();
      offer(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3);
      chk("ind3_ex_rdy", 32'(ex_rdy), 32'd1);
      step();
      chk("ind3_busy", 32'(busy), 32'd1);
      chk("ind3_count", 32'(dut.count_reg), 32'd3);
      offer(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4);
      chk("ind4_ex_rdy", 32'(ex_rdy), 32'd1);
      step();
      chk("ind4_count", 32'(dut.count_reg), 32'd4);
      offer(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd5);
      chk("full_ex_rdy", 32'(ex_rdy), 32'd0);
      chk("full_id_ack", 32'(id_ack), 32'd0);

      // Retire at full with an issue offered: blocked this cycle, issues the next
      wb_retire = 1'b1;
      #1;
      chk("fullpop_ex_rdy", 32'(ex_rdy), 32'd0);
      step();
      wb_retire = 1'b0;
      chk("fullpop_count", 32'(dut.count_reg), 32'd3);
      #1;
      chk("after_pop_ex_rdy", 32'(ex_rdy), 32'd1);
      step();
      chk("wrap_count", 32'(dut.count_reg), 32'd4);
      retire_one();
      chk("wrap_count3", 32'(dut.count_reg), 32'd3);
      offer(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0);
      chk("retired_x2_free", 32'(ex_rdy), 32'd1);
      offer(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0);
      chk("wrapped_x5_blocks", 32'(ex_rdy), 32'd0);
      offer(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0);
      chk("x3_blocks", 32'(ex_rdy), 32'd0);
      retire_one();
      retire_one();
      retire_one();
      chk("drain_busy", 32'(busy), 32'd0);
      chk("drain_sb_err", 32'(sb_err), 32'd0);

      // RAW stall: three blocked cycles, retire in the third, issue in the fourth
      pulse_clr();
      offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5);
      step();
      offer(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6);
      chk("raw_c1_ex_rdy", 32'(ex_rdy), 32'd0);
      step();
      #1;
      chk("raw_c2_ex_rdy", 32'(ex_rdy), 32'd0);
      step();
      wb_retire = 1'b1;
      #1;
      chk("raw_c3_ex_rdy", 32'(ex_rdy), 32'd0);
      step();
      wb_retire = 1'b0;
      #1;
      chk("raw_c4_ex_rdy", 32'(ex_rdy), 32'd1);
      chk("raw_c4_id_ack", 32'(id_ack), 32'd1);
      chk("raw_stall_cnt", stall_cnt, PERF ? 32'd3 : 32'd0);
      step();
      chk("raw_busy", 32'(busy), 32'd1);
      retire_one();
      chk("raw_drain_busy", 32'(busy), 32'd0);

      // x0 destination and unused / x0 sources
      offer(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
      chk("rsd0_ex_rdy", 32'(ex_rdy), 32'd1);
      step();
      chk("rsd0_busy", 32'(busy), 32'd0);
      offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7);
      step();
      offer(1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd0);
      chk("unused_rs1_ex_rdy", 32'(ex_rdy), 32'd1);
      offer(1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 5'd0);
      chk("used_rs2_x7_ex_rdy", 32'(ex_rdy), 32'd0);
      offer(1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd0);
      ex_ack = 1'b0;
      #1;
      chk("no_ack_id_ack", 32'(id_ack), 32'd0);
      chk("no_ack_ex_rdy", 32'(ex_rdy), 32'd1);
      step();
      chk("no_ack_count", 32'(dut.count_reg), 32'd1);
      ex_ack = 1'b1;
      #1;
      step();
      chk("x0_issue_count", 32'(dut.count_reg), 32'd1);
      retire_one();
      chk("x0_drain_busy", 32'(busy), 32'd0);

      // Stall counter: 5 stalls, then clear with a concurrent stall
      offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9);
      step();
      pulse_clr();
      offer(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0);
      for (int i = 0; i < 5; i++) step();
      id_rdy = 1'b0;
      #1;
      chk("cnt_five", stall_cnt, PERF ? 32'd5 : 32'd0);
      id_rdy    = 1'b1;
      stall_clr = 1'b1;
      step();
      stall_clr = 1'b0;
      chk("cnt_cleared", stall_cnt, 32'd0);
`ifdef RISCV_ISSUE_PERF_EN
      id_rdy = 1'b0;
      force dut.stall_cnt_reg = 32'hFFFF_FFFD;
      #1;
      release dut.stall_cnt_reg;
      id_rdy = 1'b1;
      step();
      step();
      step();
      chk("cnt_saturate", stall_cnt, 32'hFFFF_FFFF);
`endif
      retire_one();
      chk("cnt_drain_busy", 32'(busy), 32'd0);

      // Retire while empty sets a sticky error
      retire_one();
      chk("err_set", 32'(sb_err), 32'd1);
      step();
      step();
      chk("err_sticky", 32'(sb_err), 32'd1);

      // Asynchronous reset mid-stream
      offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3);
      step();
      offer(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4);
      step();
      step();
      chk("pre_rst_busy", 32'(busy), 32'd1);
      offer(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4);
      #1;
      rstn = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_sb_err", 32'(sb_err), 32'd0);
      chk("mid_rst_stall_cnt", stall_cnt, 32'd0);
      chk("mid_rst_ex_rdy", 32'(ex_rdy), 32'd0);
      chk("mid_rst_id_ack", 32'(id_ack), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
